// File: rtl/mux_pkg.sv
// Shared definitions for the scanning N:1 registered multiplexer.
// Mode encodings, scan FSM states and the out-of-range select policy.
package mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic {
        ST_DIRECT = 1'b0,
        ST_SCAN   = 1'b1
    } state_e;

    // Out-of-range direct selects drive zero rather than holding
    // the previous value.
    localparam bit OOR_ZERO_FILL = 1'b1;

    function automatic state_e mode_to_state(input logic m);
        return (m == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
    endfunction

endpackage

// File: rtl/mux_scan_ctr.sv
// Channel/dwell counter for auto-scan: holds each channel for DWELL
// enabled cycles, wraps by compare at N_CH-1.
// Ports: clk, rst (async high), clear, en -> ch_cnt, wrap.
module mux_scan_ctr
    import mux_pkg::*;
#(
    parameter int N_CH  = 9,
    parameter int DWELL = 1,
    localparam int SEL_W = $clog2(N_CH),
    localparam int DW_W  = $clog2(DWELL + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    output logic [SEL_W-1:0] ch_cnt,
    output logic             wrap
);

    localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(N_CH - 1);
    localparam logic [DW_W-1:0]  DW_LAST = DW_W'(DWELL - 1);

    logic [SEL_W-1:0] ch_cnt_q, ch_cnt_d;
    logic [DW_W-1:0]  dwell_cnt_q, dwell_cnt_d;
    logic             dwell_last;
    logic             ch_last;

    assign dwell_last = (dwell_cnt_q == DW_LAST);
    assign ch_last    = (ch_cnt_q == CH_LAST);

    always_comb begin
        ch_cnt_d    = ch_cnt_q;
        dwell_cnt_d = dwell_cnt_q;
        if (clear) begin
            ch_cnt_d    = '0;
            dwell_cnt_d = '0;
        end else if (en) begin
            if (dwell_last) begin
                dwell_cnt_d = '0;
                ch_cnt_d    = ch_last ? '0 : ch_cnt_q + 1'b1;
            end else begin
                dwell_cnt_d = dwell_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_cnt_q    <= '0;
            dwell_cnt_q <= '0;
        end else begin
            ch_cnt_q    <= ch_cnt_d;
            dwell_cnt_q <= dwell_cnt_d;
        end
    end

    assign ch_cnt = ch_cnt_q;
    // Final sample of the last channel: the counter is about to wrap.
    assign wrap   = en && !clear && dwell_last && ch_last;

endmodule

// File: rtl/mux_scan_nx1.sv
// N-channel WIDTH-bit registered mux with direct select or auto-scan.
// Ports: clk, rst, en, mode, sel, din -> dout, dout_valid, ch_out,
// sel_err, scan_wrap (all outputs registered, 1-cycle latency).
module mux_scan_nx1
    import mux_pkg::*;
#(
    parameter int N_CH  = 9,
    parameter int WIDTH = 1,
    parameter int DWELL = 1,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH*WIDTH-1:0] din,
    output logic [WIDTH-1:0]      dout,
    output logic                  dout_valid,
    output logic [SEL_W-1:0]      ch_out,
    output logic                  sel_err,
    output logic                  scan_wrap
);

    localparam logic [SEL_W:0] N_CH_W = (SEL_W + 1)'(N_CH);

    state_e           state_q, state_d;
    logic             scan;
    logic             ctr_clear;
    logic             ctr_en;
    logic [SEL_W-1:0] ch_cnt;
    logic             ctr_wrap;
    logic [SEL_W-1:0] idx;
    logic             in_range;
    logic [WIDTH-1:0] pick;

    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] ch_out_q, ch_out_d;
    logic             sel_err_q, sel_err_d;
    logic             wrap_q, wrap_d;

    // The incoming mode governs the sample taken on this edge.
    assign state_d   = mode_to_state(mode);
    assign scan      = (state_d == ST_SCAN);
    // Counters are zeroed on leaving scan and stay idle in direct,
    // so re-entering scan always starts at channel 0, dwell 0.
    assign ctr_clear = (state_q == ST_SCAN) && !scan;
    assign ctr_en    = en && scan;

    mux_scan_ctr #(
        .N_CH  (N_CH),
        .DWELL (DWELL)
    ) u_ctr (
        .clk    (clk),
        .rst    (rst),
        .clear  (ctr_clear),
        .en     (ctr_en),
        .ch_cnt (ch_cnt),
        .wrap   (ctr_wrap)
    );

    assign idx      = scan ? ch_cnt : sel;
    assign in_range = ({1'b0, idx} < N_CH_W);

    // Compare-based select: codes with no channel yield zero.
    always_comb begin
        pick = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (idx == SEL_W'(k)) begin
                pick = din[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        dout_d    = dout_q;
        ch_out_d  = ch_out_q;
        sel_err_d = sel_err_q;
        valid_d   = 1'b0;
        wrap_d    = 1'b0;
        if (en) begin
            valid_d  = 1'b1;
            ch_out_d = idx;
            if (scan) begin
                dout_d    = pick;
                sel_err_d = 1'b0;
                wrap_d    = ctr_wrap;
            end else if (in_range) begin
                dout_d    = pick;
                sel_err_d = 1'b0;
            end else begin
                dout_d    = OOR_ZERO_FILL ? '0 : dout_q;
                sel_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_DIRECT;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            ch_out_q  <= '0;
            sel_err_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            ch_out_q  <= ch_out_d;
            sel_err_q <= sel_err_d;
            wrap_q    <= wrap_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign ch_out     = ch_out_q;
    assign sel_err    = sel_err_q;
    assign scan_wrap  = wrap_q;

endmodule

// File: doc/mux_scan_nx1.md
Name: mux_scan_nx1

Overview:
- Parametrised N-channel, WIDTH-bit registered multiplexer.
- Generalises the fixed 9:1 single-bit combinational mux.
- Two operating modes:
  - Direct select: the channel is chosen by the sel input.
  - Auto-scan: an internal counter steps through all channels, holding each for DWELL enabled cycles.
- Used as the channel-selection front end for status/sensor sampling. Out-of-range select codes are flagged instead of silently aliased.

Parameters:
- N_CH, 9: number of input channels; legal range 2..256.
- WIDTH, 1: bits per channel.
- SEL_W, $clog2(N_CH): select/channel-index width (4 for N_CH=9); derived, never overridden.
- DWELL, 1: enabled cycles spent on each channel in scan mode; legal range ≥1.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-high reset.
- en, input, 1: sample enable; when low, all state holds.
- mode, input, 1: 0 = direct select, 1 = auto-scan.
- sel, input, SEL_W: channel index in direct mode; ignored in scan mode.
- din, input, N_CH*WIDTH: packed channels; channel k = din[k*WIDTH +: WIDTH].
- dout, output, WIDTH: registered selected data.
- dout_valid, output, 1: dout was updated on the last edge.
- ch_out, output, SEL_W: channel index that produced dout.
- sel_err, output, 1: registered flag; the last direct-mode sample used sel ≥ N_CH.
- scan_wrap, output, 1: one-cycle pulse marking the last sample of channel N_CH-1 before wrap to 0.

Behaviour:
- Reset (async, immediate, any state):
  - Outputs: dout=0, dout_valid=0, ch_out=0, sel_err=0, scan_wrap=0.
  - Internal: state=DIRECT, ch_cnt=0, dwell_cnt=0.
- Latency: 1 cycle. Outputs reflect din/sel/mode sampled at the previous rising edge when en=1.
- States: DIRECT and SCAN. The state register follows mode on every edge regardless of en.
  - DIRECT→SCAN: ch_cnt=0, dwell_cnt=0. The first scan sample is channel 0 on the first enabled edge in SCAN.
  - SCAN→DIRECT: counters cleared.
- Sampling on the same edge as a mode change: the new mode's rules apply.
- en=0: dout, ch_out and sel_err hold; dout_valid=0; scan_wrap=0; counters frozen.
- DIRECT, en=1:
  - sel < N_CH: dout=din[sel], ch_out=sel, sel_err=0.
  - sel ≥ N_CH: dout=0, ch_out=sel, sel_err=1.
  - dout_valid=1 in both cases.
- SCAN, en=1:
  - dout=din[ch_cnt], ch_out=ch_cnt, dout_valid=1, sel_err=0.
  - dwell_cnt increments each enabled cycle.
  - When dwell_cnt==DWELL-1: dwell_cnt→0 and ch_cnt advances.
  - At ch_cnt==N_CH-1, ch_cnt wraps to 0 and scan_wrap=1 alongside that sample.
- Width rules:
  - ch_cnt and dwell_cnt never exceed N_CH-1 and DWELL-1; wrap by compare, not by power-of-two overflow.
  - dwell_cnt width is $clog2(DWELL+1).
- Non-power-of-two N_CH must never select a nonexistent channel in scan mode.
- din changes only take effect at the next enabled edge; there is no combinational path from din to dout.

Decomposition:
- Shared package mux_pkg:
  - Mode encodings MODE_DIRECT=1'b0, MODE_SCAN=1'b1.
  - State enum.
  - sel_err/out-of-range policy constant (zero output).
- One natural sub-module: mux_scan_ctr, the channel/dwell counter.
  - Inputs: clk, rst, clear, en.
  - Outputs: ch_cnt, wrap.
  - Parameters: N_CH, DWELL.
- The top level holds the state register, the output mux and the output registers.

Test Plan:
1. Reset mid-operation: SCAN active at ch 5, assert rst between edges → all outputs 0 immediately. After release with mode=1, en=1: first sample is ch 0.
2. Direct select, N_CH=9, WIDTH=1: din=9'b1_0101_0101, sel=4'b0010 → next cycle dout=1, ch_out=2, sel_err=0, dout_valid=1. Then sel=4'b0011 → dout=0.
3. Out of range: sel=4'b1111, din=all ones → dout=0, sel_err=1, ch_out=15. Then sel=4'b1000 → dout=din[8]=1, sel_err=0.
4. Scan wrap, DWELL=1, din=9'b1_1111_0000, mode=1, en=1 for 10 cycles:
   - ch_out sequence 0..8 then 0.
   - dout = 0,0,0,0,1,1,1,1,1,0.
   - scan_wrap high only with the ch 8 sample.
5. Dwell and hold, DWELL=3: each ch_out held 3 valid samples. Drop en for 2 cycles mid-dwell → dout/ch_out hold, dout_valid=0, dwell resumes at the same count.
6. Mode switch: in SCAN at ch 4, switch to DIRECT with sel=7 → next sample ch_out=7. Switch back to SCAN → restarts at ch 0, dwell 0.
